mix_column_engine: RTL and testbench
====================================

MIX_COLUMN_ENGINE -- requirements
Module: mix_column_engine

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1, columns transformed per clock; legal values 1, 2, 4.
REQ-002 Parameter INV_EN, default 1; 1 builds the inverse datapath, 0 builds forward only.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  din/mode present.
REQ-006 in_ready  output  1  engine accepts a block.
REQ-007 mode  input  1  0 = MixColumns (02 03 01 01), 1 = InvMixColumns (0e 0b 0d 09).
REQ-008 din  input  128  state; column 0 = din[127:96], row 0 = MSB byte of each column.
REQ-009 out_valid  output  1  dout holds a finished block.
REQ-010 out_ready  input  1  consumer takes dout.
REQ-011 dout  output  128  transformed state, same column/byte order as din.

Function
REQ-012 FSM states: IDLE, BUSY, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 An accept occurs when in_valid and in_ready are both 1. On accept, din is loaded into the working register, mode is latched, the column counter is cleared, and the FSM moves IDLE->BUSY.
REQ-015 In BUSY, each cycle transforms COLS_PER_CYCLE columns in place, starting at column 0 and taking columns in ascending order; the counter advances by COLS_PER_CYCLE.
REQ-016 After the cycle that processes column 3, the FSM moves BUSY->DONE.
REQ-017 Latency from the accept edge to out_valid=1 SHALL be exactly 4/COLS_PER_CYCLE cycles.
REQ-018 In DONE, dout and out_valid are held stable until out_ready=1; that edge moves DONE->IDLE.
REQ-019 Minimum spacing between accepts SHALL be 4/COLS_PER_CYCLE+2 cycles when out_ready is tied to 1.
REQ-020 in_valid is ignored outside IDLE; din and mode changes during BUSY or DONE do not affect the result.
REQ-021 GF(2^8) arithmetic SHALL use reduction polynomial 0x11b; xtime(b) = {b[6:0],0} XOR (0x1b if b[7]).
REQ-022 If INV_EN=0, mode is ignored and the forward transform is always applied.
REQ-023 dout SHALL equal the working register; its value is defined only while out_valid=1.
REQ-024 Counter width is 2 bits and wraps to 0 on the BUSY->DONE transition.

Reset
REQ-025 While rst_n=0 and immediately after release: state = IDLE, in_ready=1, out_valid=0, dout=0, counter=0, latched mode=0.
REQ-026 Assertion of rst_n in BUSY or DONE SHALL discard the block in flight; no out_valid follows it.

Structure
REQ-027 Shared package aes_pkg SHALL hold the FSM state enum, the polynomial constant 8'h1b, the forward and inverse coefficient constants, and the xtime function.
REQ-028 Sub-module mix_col_word (32-bit combinational, one column, forward/inverse select) SHALL be instantiated COLS_PER_CYCLE times; the top block holds the FSM, counter, and column muxing.

Verification
REQ-029 Forward test, COLS_PER_CYCLE=1: din=db135345_f20a225c_01010101_2d26314c, mode=0 -> dout=8e4da1bc_9fdc589d_01010101_4d7ebdf8, out_valid 4 cycles after accept.
REQ-030 Inverse test: din=8e4da1bc_9fdc589d_01010101_4d7ebdf8, mode=1 -> dout=db135345_f20a225c_01010101_2d26314c; repeat with COLS_PER_CYCLE=4 and check 1-cycle latency.
REQ-031 Symmetric input: din=c6c6c6c6_d4d4d4d5_01010101_c6c6c6c6, mode=0, COLS_PER_CYCLE=2 -> dout=c6c6c6c6_d5d5d7d6_01010101_c6c6c6c6, latency 2.
REQ-032 Backpressure: out_ready=0 for 10 cycles in DONE -> dout and out_valid stable; in_ready=0 throughout; a new in_valid pulse during this time is not accepted.
REQ-033 Reset during BUSY at cycle 2 -> out_valid never rises for that block; next accept after release produces a correct result.
REQ-034 INV_EN=0, mode=1 with the REQ-029 din -> forward result 8e4da1bc_9fdc589d_01010101_4d7ebdf8.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM states, GF(2^8) constants and helpers for the MixColumns engine
package aes_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] POLY = 8'h1b;
  localparam logic [31:0] FWD_COEF = 32'h02030101;
  localparam logic [31:0] INV_COEF = 32'h0e0b0d09;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
  endfunction
  // shift-and-add multiply; constant coefficients fold away in synthesis
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] p, acc;
    p = b;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      acc ^= c[i] ? p : 8'h00;
      p = xtime(p);
    end
    return acc;
  endfunction
endpackage

// File: rtl/mix_col_word.sv
// mix_col_word: one-column (Inv)MixColumns, combinational
module mix_col_word
  import aes_pkg::*;
#(
  parameter int INV_EN = 1
) (
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] result
);
  logic [31:0] coef;
  assign coef = (INV_EN != 0 && inv) ? INV_COEF : FWD_COEF;
  // row r multiplies byte j by the circulant coefficient at (j - r) mod 4
  always_comb begin
    result = '0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        result[31-8*r -: 8] ^= gmul(col[31-8*j -: 8], coef[31-8*((j-r)&3) -: 8]);
  end
endmodule

// File: rtl/mix_column_engine.sv
// mix_column_engine: iterative AES (Inv)MixColumns over a 128-bit state
module mix_column_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int INV_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout
);
  // STEP truncates to 0 when all four columns go at once, so the counter stays at 0
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
  state_t state, state_n;
  logic [127:0] work, work_n;
  logic mode_q, accept;
  logic [1:0] cnt;
  logic [1:0] idx [COLS_PER_CYCLE];
  logic [31:0] col_in [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign dout = work;
  assign accept = in_valid && in_ready;
  genvar g;
  generate
    for (g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign idx[g] = cnt + 2'(g);
      assign col_in[g] = work[127-32*idx[g] -: 32];
      mix_col_word #(.INV_EN(INV_EN)) u_mix (
        .col(col_in[g]),
        .inv(mode_q),
        .result(col_out[g])
      );
    end
  endgenerate
  always_comb begin
    work_n = work;
    for (int k = 0; k < COLS_PER_CYCLE; k++)
      work_n[127-32*idx[k] -: 32] = col_out[k];
  end
  always_comb begin
    state_n = accept ? BUSY :
              (state == BUSY && cnt == LAST) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work <= '0;
      mode_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        work <= din;
        mode_q <= mode;
        cnt <= '0;
      end else if (state == BUSY) begin
        work <= work_n;
        cnt <= cnt + STEP;
      end
    end
  end
endmodule

// File: tb/tb_mix_column_engine.sv
// tb_mix_column_engine: directed checks across COLS_PER_CYCLE 1/2/4 and a forward-only build
module tb_mix_column_engine;
  localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] SYM_IN  = 128'hc6c6c6c6_d4d4d4d5_01010101_c6c6c6c6;
  localparam logic [127:0] SYM_OUT = 128'hc6c6c6c6_d5d5d7d6_01010101_c6c6c6c6;
  logic clk = 0, rst_n = 0, in_valid = 0, mode = 0, out_ready = 1;
  logic [127:0] din = '0;
  logic in_ready [4];
  logic out_valid [4];
  logic [127:0] dout [4];
  int checks = 0, errors = 0;
  int first [4];
  logic [127:0] res [4];
  int lat [4] = '{4, 2, 1, 4};
  logic seen;
  always #5 clk = ~clk;
  mix_column_engine #(.COLS_PER_CYCLE(1), .INV_EN(1)) dut_c1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .mode(mode), .din(din), .out_valid(out_valid[0]), .out_ready(out_ready), .dout(dout[0]));
  mix_column_engine #(.COLS_PER_CYCLE(2), .INV_EN(1)) dut_c2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .mode(mode), .din(din), .out_valid(out_valid[1]), .out_ready(out_ready), .dout(dout[1]));
  mix_column_engine #(.COLS_PER_CYCLE(4), .INV_EN(1)) dut_c4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .mode(mode), .din(din), .out_valid(out_valid[2]), .out_ready(out_ready), .dout(dout[2]));
  mix_column_engine #(.COLS_PER_CYCLE(1), .INV_EN(0)) dut_fw (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[3]), .mode(mode), .din(din), .out_valid(out_valid[3]), .out_ready(out_ready), .dout(dout[3]));
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one accept, then din/mode scrambled while the block is in flight
  task automatic run(input logic [127:0] d, input logic m);
    for (int i = 0; i < 4; i++) begin
      first[i] = -1;
      res[i] = '0;
    end
    in_valid = 1;
    din = d;
    mode = m;
    @(posedge clk); #1;
    in_valid = 0;
    din = ~d;
    mode = ~m;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (out_valid[i] === 1'b1 && first[i] < 0) begin
          first[i] = k;
          res[i] = dout[i];
        end
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_in_ready%0d", i), 128'(in_ready[i]), 128'(1));
      check($sformatf("rst_out_valid%0d", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("rst_dout%0d", i), dout[i], '0);
    end
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post_rst_in_ready%0d", i), 128'(in_ready[i]), 128'(1));
      check($sformatf("post_rst_out_valid%0d", i), 128'(out_valid[i]), 128'(0));
    end
    run(FWD_IN, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fwd_dout%0d", i), res[i], FWD_OUT);
      check($sformatf("fwd_lat%0d", i), 128'(first[i]), 128'(lat[i]));
    end
    run(FWD_OUT, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("inv_dout%0d", i), res[i], FWD_IN);
      check($sformatf("inv_lat%0d", i), 128'(first[i]), 128'(lat[i]));
    end
    run(FWD_IN, 1'b1);
    check("fwd_only_mode1_dout", res[3], FWD_OUT);
    check("fwd_only_mode1_lat", 128'(first[3]), 128'(4));
    run(SYM_IN, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sym_dout%0d", i), res[i], SYM_OUT);
      check($sformatf("sym_lat%0d", i), 128'(first[i]), 128'(lat[i]));
    end
    out_ready = 0;
    in_valid = 1;
    din = FWD_IN;
    mode = 0;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 3);
      din = SYM_IN;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("bp_out_valid%0d_c%0d", i, c), 128'(out_valid[i]), 128'(1));
        check($sformatf("bp_in_ready%0d_c%0d", i, c), 128'(in_ready[i]), 128'(0));
        check($sformatf("bp_dout%0d_c%0d", i, c), dout[i], FWD_OUT);
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_release_out_valid%0d", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("bp_release_in_ready%0d", i), 128'(in_ready[i]), 128'(1));
    end
    in_valid = 1;
    din = FWD_IN;
    mode = 0;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    check("abort_busy_c1", 128'(out_valid[0]), 128'(0));
    rst_n = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort_rst_out_valid%0d", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("abort_rst_in_ready%0d", i), 128'(in_ready[i]), 128'(1));
      check($sformatf("abort_rst_dout%0d", i), dout[i], '0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) seen |= (out_valid[i] !== 1'b0);
    end
    check("abort_no_out_valid", 128'(seen), 128'(0));
    run(FWD_IN, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("after_abort_dout%0d", i), res[i], FWD_OUT);
      check($sformatf("after_abort_lat%0d", i), 128'(first[i]), 128'(lat[i]));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
